sd_memory_cntl: RTL and testbench

Descriptor-walk controller and arbiter in front of the Manager's storage-descriptor memory (`sd_memory`). It accepts storage-descriptor pointers from up to `NUM_REQ` requesters and grants the memory to one requester at a time using round-robin. For the granted requester it issues back-to-back reads starting at the pointer until the descriptor terminates. It forwards each valid entry's handshake, tagged with the requester id, and discards over-fetched reads.

---
 rtl/sd_memory_cntl_pkg.sv | 36 +++
 rtl/sd_memory_cntl_rr_arbiter.sv | 35 +++
 rtl/sd_memory_cntl.sv | 162 ++++++++++++++++
 tb/tb_sd_memory_cntl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_memory_cntl_pkg.sv
// Shared constants and types for the storage-descriptor memory controller:
// dcntl delineator encodings, FSM states and default sizes.
package sd_memory_cntl_pkg;

  localparam int MGR_NUM_REQ  = 4;
  localparam int SDM_ADDR_W   = 10;
  localparam int SDM_MAX_DESC = 16;

  typedef enum logic [1:0] {
    DCNTL_MOM     = 2'b00,
    DCNTL_SOM     = 2'b01,
    DCNTL_EOM     = 2'b10,
    DCNTL_SOM_EOM = 2'b11
  } dcntl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Entry opens a descriptor (SOM or SOM_EOM).
  function automatic logic dcntl_is_start(input logic [1:0] d);
    return (d == DCNTL_SOM) || (d == DCNTL_SOM_EOM);
  endfunction

  // Entry closes a descriptor (EOM or SOM_EOM).
  function automatic logic dcntl_is_end(input logic [1:0] d);
    return (d == DCNTL_EOM) || (d == DCNTL_SOM_EOM);
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_memory_cntl_rr_arbiter.sv
// Round-robin requester selection: first request at or after rr_ptr, with wrap.
// Purely combinational; the pointer register lives in the parent.
module sdc_rr_arbiter
  import sd_memory_cntl_pkg::*;
#(
  parameter int NUM_REQ = MGR_NUM_REQ,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sd_memory_cntl.sv
// Descriptor-walk controller: arbitrates requesters onto sd_memory, streams reads
// from the granted pointer until the descriptor ends, and tags valid responses.
module sd_memory_cntl
  import sd_memory_cntl_pkg::*;
#(
  parameter int NUM_REQ  = MGR_NUM_REQ,
  parameter int ADDR_W   = SDM_ADDR_W,
  parameter int MAX_DESC = SDM_MAX_DESC,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_poweron,
  input  logic [NUM_REQ-1:0]             req__sdc__valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req__sdc__ptr,
  output logic [NUM_REQ-1:0]             sdc__req__ready,
  output logic                           sdc__sdm__read,
  output logic [ADDR_W-1:0]              sdc__sdm__addr,
  input  logic                           sdm__sdc__valid,
  input  logic [1:0]                     sdm__sdc__dcntl,
  output logic                           sdc__xx1__rsp_valid,
  output logic [ID_W-1:0]                sdc__xx1__rsp_id,
  output logic                           sdc__xx1__rsp_last,
  output logic                           sdc__xx1__rsp_error
);

  localparam int CNT_W = $clog2(MAX_DESC + 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic [1:0]        outst_q, outst_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic [ID_W-1:0]    rr_next;

  logic first_entry;
  logic last_slot;
  logic entry_err;
  logic entry_term;
  logic terminate;
  logic budget_left;

  sdc_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req    (req__sdc__valid),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .id     (arb_id),
    .any    (arb_any)
  );

  assign rr_next = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + ID_W'(1);

  // Classification of the returning entry; only consumed while in ISSUE.
  assign first_entry = (rsp_cnt_q == '0);
  assign last_slot   = (rsp_cnt_q == CNT_W'(MAX_DESC - 1));
  assign entry_err   = (first_entry && !dcntl_is_start(sdm__sdc__dcntl))
                     || (!first_entry && dcntl_is_start(sdm__sdc__dcntl))
                     || (last_slot && (sdm__sdc__dcntl != DCNTL_EOM));
  assign entry_term  = entry_err || dcntl_is_end(sdm__sdc__dcntl);
  assign terminate   = sdm__sdc__valid && entry_term;
  assign budget_left = (issued_q < CNT_W'(MAX_DESC));

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    id_d                = id_q;
    addr_d              = addr_q;
    issued_d            = issued_q;
    rsp_cnt_d           = rsp_cnt_q;
    outst_d             = outst_q;
    sdc__req__ready     = '0;
    sdc__sdm__read      = 1'b0;
    sdc__sdm__addr      = '0;
    sdc__xx1__rsp_valid = 1'b0;
    sdc__xx1__rsp_id    = '0;
    sdc__xx1__rsp_last  = 1'b0;
    sdc__xx1__rsp_error = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Late returns from a walk cut short by reset are ignored here.
        outst_d = '0;
        if (arb_any && !reset_poweron) begin
          sdc__req__ready = arb_gnt;
          sdc__sdm__read  = 1'b1;
          sdc__sdm__addr  = req__sdc__ptr[arb_id];
          id_d            = arb_id;
          rr_ptr_d        = rr_next;
          addr_d          = req__sdc__ptr[arb_id] + ADDR_W'(1);
          issued_d        = CNT_W'(1);
          rsp_cnt_d       = '0;
          outst_d         = 2'd1;
          state_d         = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (sdm__sdc__valid) begin
          sdc__xx1__rsp_valid = 1'b1;
          sdc__xx1__rsp_id    = id_q;
          sdc__xx1__rsp_last  = entry_term;
          sdc__xx1__rsp_error = entry_err;
          rsp_cnt_d           = rsp_cnt_q + CNT_W'(1);
        end
        // A terminating return suppresses the read in the same cycle.
        sdc__sdm__read = budget_left && !terminate;
        if (sdc__sdm__read) begin
          sdc__sdm__addr = addr_q;
          addr_d         = addr_q + ADDR_W'(1);
          issued_d       = issued_q + CNT_W'(1);
        end
        outst_d = outst_q + {1'b0, sdc__sdm__read} - {1'b0, sdm__sdc__valid};
        if (terminate) begin
          state_d = (outst_d == '0) ? ST_IDLE : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (sdm__sdc__valid) begin
          outst_d = outst_q - 2'd1;
        end
        if (outst_d == '0) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      issued_q  <= '0;
      rsp_cnt_q <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      rsp_cnt_q <= rsp_cnt_d;
      outst_q   <= outst_d;
    end
  end

endmodule

// File: tb/tb_sd_memory_cntl.sv
// Directed bench for sd_memory_cntl with a 2-cycle-latency sd_memory model
// and per-cycle logging of grants, reads and responses.
module tb_sd_memory_cntl;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 10;
  localparam int MAX_DESC = 16;
  localparam int ID_W     = 2;

  localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SOM_EOM = 2'b11;

  logic                           clk = 1'b0;
  logic                           reset_poweron;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_ptr;
  logic [NUM_REQ-1:0]             ready;
  logic                           read;
  logic [ADDR_W-1:0]              addr;
  logic                           sdm_valid;
  logic [1:0]                     dcntl;
  logic                           rsp_valid;
  logic [ID_W-1:0]                rsp_id;
  logic                           rsp_last;
  logic                           rsp_error;

  always #5 clk = ~clk;

  sd_memory_cntl #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_DESC(MAX_DESC)
  ) dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .req__sdc__valid     (req_valid),
    .req__sdc__ptr       (req_ptr),
    .sdc__req__ready     (ready),
    .sdc__sdm__read      (read),
    .sdc__sdm__addr      (addr),
    .sdm__sdc__valid     (sdm_valid),
    .sdm__sdc__dcntl     (dcntl),
    .sdc__xx1__rsp_valid (rsp_valid),
    .sdc__xx1__rsp_id    (rsp_id),
    .sdc__xx1__rsp_last  (rsp_last),
    .sdc__xx1__rsp_error (rsp_error)
  );

  // sd_memory model: data returns exactly two cycles after the read.
  logic [1:0]        mem [0:(1<<ADDR_W)-1];
  logic              p1_v = 1'b0, p2_v = 1'b0;
  logic [ADDR_W-1:0] p1_a = '0, p2_a = '0;

  always @(posedge clk) begin
    p1_v <= read;
    p1_a <= addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end

  assign sdm_valid = p2_v;
  assign dcntl     = p2_v ? mem[p2_a] : 2'b00;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stray = 0;

  int                 rdy_c[$];
  logic [NUM_REQ-1:0] rdy_v[$];
  int                 rd_c[$];
  logic [ADDR_W-1:0]  rd_a[$];
  int                 rv_c[$];
  logic [ID_W-1:0]    rv_id[$];
  logic               rv_last[$];
  logic               rv_err[$];

  task automatic clear_log();
    rdy_c.delete(); rdy_v.delete(); rd_c.delete(); rd_a.delete();
    rv_c.delete(); rv_id.delete(); rv_last.delete(); rv_err.delete();
  endtask

  // One clock: log outputs at the falling edge, then drop any granted request.
  task automatic step();
    logic [NUM_REQ-1:0] seen;
    @(negedge clk);
    seen = ready;
    if (ready != '0) begin rdy_c.push_back(cyc); rdy_v.push_back(ready); end
    if (read) begin rd_c.push_back(cyc); rd_a.push_back(addr); end
    if (rsp_valid) begin
      rv_c.push_back(cyc); rv_id.push_back(rsp_id);
      rv_last.push_back(rsp_last); rv_err.push_back(rsp_error);
    end
    if ((rsp_last || rsp_error) && !rsp_valid) stray++;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~seen;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset_poweron = 1'b1;
    req_valid     = '0;
    run(3);
    tests++; if (ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", ready); end
    tests++; if (read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b expected 0", read); end
    tests++; if (addr !== 10'h000) begin fails++; $display("FAIL reset_addr: got %h expected 000", addr); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    tests++; if (rsp_last !== 1'b0) begin fails++; $display("FAIL reset_rsp_last: got %b expected 0", rsp_last); end
    tests++; if (rsp_error !== 1'b0) begin fails++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
    reset_poweron = 1'b0;
    run(1);
  endtask

  task automatic test_single_walk();
    int g;
    mem[10'h010] = SOM; mem[10'h011] = MOM; mem[10'h012] = MOM; mem[10'h013] = EOM;
    clear_log();
    req_ptr[0] = 10'h010;
    req_valid  = 4'b0001;
    run(16);
    tests++; if (rdy_c.size() != 1) begin fails++; $display("FAIL walk_grant_count: got %0d expected 1", rdy_c.size()); end
    g = (rdy_c.size() > 0) ? rdy_c[0] : -100;
    if (rdy_v.size() > 0) begin
      tests++; if (rdy_v[0] !== 4'b0001) begin fails++; $display("FAIL walk_grant_vec: got %b expected 0001", rdy_v[0]); end
    end
    // Four real reads plus one over-fetch before EOM suppresses issue.
    tests++; if (rd_c.size() != 5) begin fails++; $display("FAIL walk_read_count: got %0d expected 5", rd_c.size()); end
    for (int k = 0; k < rd_c.size() && k < 5; k++) begin
      tests++; if (rd_c[k] != g + k) begin fails++; $display("FAIL walk_read_cycle[%0d]: got %0d expected %0d", k, rd_c[k], g + k); end
      tests++; if (rd_a[k] !== 10'(16 + k)) begin fails++; $display("FAIL walk_read_addr[%0d]: got %h expected %h", k, rd_a[k], 10'(16 + k)); end
    end
    tests++; if (rv_c.size() != 4) begin fails++; $display("FAIL walk_rsp_count: got %0d expected 4", rv_c.size()); end
    for (int k = 0; k < rv_c.size() && k < 4; k++) begin
      tests++; if (rv_c[k] != g + 2 + k) begin fails++; $display("FAIL walk_rsp_cycle[%0d]: got %0d expected %0d", k, rv_c[k], g + 2 + k); end
      tests++; if (rv_id[k] !== 2'd0) begin fails++; $display("FAIL walk_rsp_id[%0d]: got %0d expected 0", k, rv_id[k]); end
      tests++; if (rv_last[k] !== (k == 3)) begin fails++; $display("FAIL walk_rsp_last[%0d]: got %b expected %b", k, rv_last[k], (k == 3)); end
      tests++; if (rv_err[k] !== 1'b0) begin fails++; $display("FAIL walk_rsp_err[%0d]: got %b expected 0", k, rv_err[k]); end
    end
  endtask

  task automatic test_round_robin();
    reset_poweron = 1'b1;
    run(2);
    reset_poweron = 1'b0;
    mem[10'h100] = SOM_EOM; mem[10'h200] = SOM_EOM; mem[10'h300] = SOM_EOM;
    clear_log();
    req_ptr[1] = 10'h100;
    req_ptr[3] = 10'h200;
    req_valid  = 4'b1010;
    run(14);
    tests++; if (rdy_c.size() != 2) begin fails++; $display("FAIL rr_grant_count: got %0d expected 2", rdy_c.size()); end
    if (rdy_c.size() >= 2) begin
      tests++; if (rdy_v[0] !== 4'b0010) begin fails++; $display("FAIL rr_first_grant: got %b expected 0010", rdy_v[0]); end
      tests++; if (rdy_v[1] !== 4'b1000) begin fails++; $display("FAIL rr_second_grant: got %b expected 1000", rdy_v[1]); end
      // SOM_EOM walk: back in IDLE four cycles after its grant.
      tests++; if (rdy_c[1] - rdy_c[0] != 4) begin fails++; $display("FAIL rr_grant_gap: got %0d expected 4", rdy_c[1] - rdy_c[0]); end
    end
    tests++; if (rv_c.size() != 2) begin fails++; $display("FAIL rr_rsp_count: got %0d expected 2", rv_c.size()); end
    if (rv_c.size() >= 2 && rdy_c.size() >= 2) begin
      tests++; if (rv_id[0] !== 2'd1) begin fails++; $display("FAIL rr_rsp_id0: got %0d expected 1", rv_id[0]); end
      tests++; if (rv_id[1] !== 2'd3) begin fails++; $display("FAIL rr_rsp_id1: got %0d expected 3", rv_id[1]); end
      tests++; if (rv_c[0] != rdy_c[0] + 2) begin fails++; $display("FAIL rr_rsp_latency: got %0d expected %0d", rv_c[0], rdy_c[0] + 2); end
      tests++; if (rv_last[0] !== 1'b1 || rv_last[1] !== 1'b1) begin fails++; $display("FAIL rr_rsp_last: got %b%b expected 11", rv_last[0], rv_last[1]); end
    end
    clear_log();
    req_ptr[0] = 10'h300;
    req_valid  = 4'b0011;
    run(14);
    tests++; if (rdy_c.size() != 2) begin fails++; $display("FAIL rr2_grant_count: got %0d expected 2", rdy_c.size()); end
    if (rdy_c.size() >= 2) begin
      tests++; if (rdy_v[0] !== 4'b0001) begin fails++; $display("FAIL rr2_first_grant: got %b expected 0001", rdy_v[0]); end
      tests++; if (rdy_v[1] !== 4'b0010) begin fails++; $display("FAIL rr2_second_grant: got %b expected 0010", rdy_v[1]); end
    end
  endtask

  task automatic test_addr_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    mem[10'h3FE] = SOM; mem[10'h3FF] = MOM; mem[10'h000] = EOM;
    clear_log();
    req_ptr[2] = 10'h3FE;
    req_valid  = 4'b0100;
    run(12);
    tests++; if (rdy_v.size() != 1 || rdy_v[0] !== 4'b0100) begin fails++; $display("FAIL wrap_grant: got %0d grants expected one to req 2", rdy_v.size()); end
    tests++; if (rd_a.size() != 4) begin fails++; $display("FAIL wrap_read_count: got %0d expected 4", rd_a.size()); end
    for (int k = 0; k < rd_a.size() && k < 4; k++) begin
      tests++; if (rd_a[k] !== exp_a[k]) begin fails++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, rd_a[k], exp_a[k]); end
    end
    tests++; if (rv_c.size() != 3) begin fails++; $display("FAIL wrap_rsp_count: got %0d expected 3", rv_c.size()); end
    if (rv_c.size() == 3) begin
      tests++; if (rv_last[2] !== 1'b1 || rv_err[2] !== 1'b0) begin fails++; $display("FAIL wrap_last: got last=%b err=%b expected last=1 err=0", rv_last[2], rv_err[2]); end
      tests++; if (rv_id[0] !== 2'd2) begin fails++; $display("FAIL wrap_rsp_id: got %0d expected 2", rv_id[0]); end
    end
  endtask

  task automatic test_bad_first();
    mem[10'h020] = MOM;
    clear_log();
    req_ptr[3] = 10'h020;
    req_valid  = 4'b1000;
    run(10);
    tests++; if (rv_c.size() != 1) begin fails++; $display("FAIL badfirst_rsp_count: got %0d expected 1", rv_c.size()); end
    if (rv_c.size() >= 1 && rdy_c.size() >= 1) begin
      tests++; if (rv_last[0] !== 1'b1) begin fails++; $display("FAIL badfirst_last: got %b expected 1", rv_last[0]); end
      tests++; if (rv_err[0] !== 1'b1) begin fails++; $display("FAIL badfirst_error: got %b expected 1", rv_err[0]); end
      tests++; if (rv_id[0] !== 2'd3) begin fails++; $display("FAIL badfirst_id: got %0d expected 3", rv_id[0]); end
      tests++; if (rv_c[0] != rdy_c[0] + 2) begin fails++; $display("FAIL badfirst_cycle: got %0d expected %0d", rv_c[0], rdy_c[0] + 2); end
    end
    tests++; if (rd_c.size() != 2) begin fails++; $display("FAIL badfirst_read_count: got %0d expected 2", rd_c.size()); end
  endtask

  task automatic test_max_desc();
    int g;
    mem[10'h040] = SOM;
    for (int k = 1; k < 21; k++) mem[10'h040 + k] = MOM;
    clear_log();
    req_ptr[0] = 10'h040;
    req_valid  = 4'b0001;
    run(26);
    g = (rdy_c.size() > 0) ? rdy_c[0] : -100;
    tests++; if (rd_c.size() != 16) begin fails++; $display("FAIL max_read_count: got %0d expected 16", rd_c.size()); end
    for (int k = 0; k < rd_c.size() && k < 16; k++) begin
      tests++; if (rd_a[k] !== 10'(64 + k) || rd_c[k] != g + k) begin fails++; $display("FAIL max_read[%0d]: got %h@%0d expected %h@%0d", k, rd_a[k], rd_c[k], 10'(64 + k), g + k); end
    end
    tests++; if (rv_c.size() != 16) begin fails++; $display("FAIL max_rsp_count: got %0d expected 16", rv_c.size()); end
    for (int k = 0; k < rv_c.size() && k < 16; k++) begin
      tests++; if (rv_last[k] !== (k == 15) || rv_err[k] !== (k == 15)) begin fails++; $display("FAIL max_rsp[%0d]: got last=%b err=%b expected %b", k, rv_last[k], rv_err[k], (k == 15)); end
    end
  endtask

  task automatic test_reset_midwalk();
    int g, n_rd, n_rv_pre, n_rv_gap;
    mem[10'h060] = SOM; mem[10'h061] = MOM; mem[10'h062] = MOM;
    mem[10'h063] = MOM; mem[10'h064] = EOM;
    mem[10'h080] = SOM_EOM; mem[10'h090] = SOM_EOM;
    clear_log();
    req_ptr[1] = 10'h060;
    req_valid  = 4'b0010;
    for (int i = 0; i < 8 && rdy_c.size() == 0; i++) step();
    tests++; if (rdy_c.size() == 0) begin fails++; $display("FAIL midreset_grant: got none expected grant within 8 cycles"); end
    g = (rdy_c.size() > 0) ? rdy_c[0] : -100;
    run(2);
    reset_poweron = 1'b1;
    step();
    reset_poweron = 1'b0;
    run(4);
    n_rd = 0; n_rv_pre = 0; n_rv_gap = 0;
    foreach (rd_c[k]) if (rd_c[k] >= g + 4 && rd_c[k] < g + 8) n_rd++;
    foreach (rv_c[k]) begin
      if (rv_c[k] < g + 4) n_rv_pre++;
      else if (rv_c[k] < g + 8) n_rv_gap++;
    end
    tests++; if (n_rd != 0) begin fails++; $display("FAIL midreset_reads: got %0d expected 0", n_rd); end
    tests++; if (n_rv_pre != 2) begin fails++; $display("FAIL midreset_rsp_before: got %0d expected 2", n_rv_pre); end
    tests++; if (n_rv_gap != 0) begin fails++; $display("FAIL midreset_rsp_after: got %0d expected 0", n_rv_gap); end
    req_ptr[0] = 10'h080;
    req_ptr[2] = 10'h090;
    req_valid  = 4'b0101;
    run(14);
    tests++; if (rdy_v.size() != 3) begin fails++; $display("FAIL midreset_grant_count: got %0d expected 3", rdy_v.size()); end
    if (rdy_v.size() >= 3) begin
      tests++; if (rdy_v[1] !== 4'b0001) begin fails++; $display("FAIL midreset_first_new: got %b expected 0001", rdy_v[1]); end
      tests++; if (rdy_v[2] !== 4'b0100) begin fails++; $display("FAIL midreset_second_new: got %b expected 0100", rdy_v[2]); end
    end
  endtask

  task automatic test_rsp_qualifiers();
    tests++; if (stray != 0) begin fails++; $display("FAIL rsp_qualifier_without_valid: got %0d cycles expected 0", stray); end
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = MOM;
    reset_poweron = 1'b1;
    req_valid     = '0;
    req_ptr       = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_walk();
    test_round_robin();
    test_addr_wrap();
    test_bad_first();
    test_max_desc();
    test_reset_midwalk();
    test_rsp_qualifiers();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
